// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light countdown display.
// Holds the phase encodings, seven-segment codes and digit-select patterns.
package traffic_pkg;

  typedef enum logic [1:0] {
    S1 = 2'b00,  // main green
    S2 = 2'b01,  // main yellow
    S3 = 2'b10,  // side green
    S4 = 2'b11   // side yellow
  } light_state_e;

  // Active-low {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low digit enables: bit0 ones, bit1 tens
  localparam logic [1:0] DIG_ONES = 2'b10;
  localparam logic [1:0] DIG_TENS = 2'b01;
  localparam logic [1:0] DIG_NONE = 2'b11;

  // Yellow phases (S2/S4) are the ones that blink
  function automatic logic is_yellow(input logic [1:0] st);
    return st[0];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment code; non-decimal blanks.
module seg7_decode
  import traffic_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    unique case (digit)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_display.sv
// Two-digit multiplexed countdown display for the traffic controller.
// Captures phase/time on tick_en, scans ones/tens slots, blinks in yellow phases.
module countdown_display
  import traffic_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 6000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic [1:0] light_state,
  input  logic [3:0] time_left,
  output logic [7:0] seg,
  output logic [1:0] dig_sel,
  output logic       blink
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  light_state_e     state_q, state_d;
  logic [3:0]       time_q, time_d;
  logic             valid_q, valid_d;
  logic             blink_q, blink_d;
  logic [1:0]       dig_sel_q, dig_sel_d;
  logic [7:0]       seg_q, seg_d;

  logic             scan_wrap_c;
  logic             tens_c;
  logic [3:0]       ones_c;
  logic [3:0]       digit_c;
  logic [7:0]       dec_seg_c;

  // Scan counter and digit alternation
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    dig_sel_d   = dig_sel_q;
    scan_wrap_c = (cnt_q == CNT_W'(SCAN_DIV - 1));
    if (scan_wrap_c) begin
      cnt_d     = '0;
      dig_sel_d = (dig_sel_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end
  end

  // Tick capture and blink phase
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    valid_d = valid_q;
    blink_d = blink_q;
    if (tick_en) begin
      state_d = light_state_e'(light_state);
      time_d  = time_left;
      valid_d = 1'b1;
      blink_d = is_yellow(light_state) ? ~blink_q : 1'b0;
    end
  end

  // Segment data is built from next-state values so seg and dig_sel switch together
  always_comb begin
    tens_c  = (time_d >= 4'd10);
    ones_c  = time_d - (tens_c ? 4'd10 : 4'd0);
    digit_c = (dig_sel_d == DIG_TENS) ? {3'b000, tens_c} : ones_c;
  end

  seg7_decode u_seg7_decode (
    .digit (digit_c),
    .seg_c (dec_seg_c)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    if (dig_sel_d == DIG_NONE) begin
      seg_d = SEG_BLANK;
    end else if (!valid_d) begin
      seg_d = SEG_DASH;
    end else if (blink_d) begin
      seg_d = SEG_BLANK;
    end else if ((dig_sel_d == DIG_TENS) && !tens_c) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = dec_seg_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      state_q   <= S1;
      time_q    <= 4'd0;
      valid_q   <= 1'b0;
      blink_q   <= 1'b0;
      dig_sel_q <= DIG_NONE;
      seg_q     <= SEG_BLANK;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      time_q    <= time_d;
      valid_q   <= valid_d;
      blink_q   <= blink_d;
      dig_sel_q <= dig_sel_d;
      seg_q     <= seg_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display with a short scan period.
module tb_countdown_display;

  localparam int unsigned SCAN_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       tick_en;
  logic [1:0] light_state;
  logic [3:0] time_left;
  logic [7:0] seg;
  logic [1:0] dig_sel;
  logic       blink;

  int checks   = 0;
  int failures = 0;

  countdown_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_en     (tick_en),
    .light_state (light_state),
    .time_left   (time_left),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .blink       (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the given slot is enabled; a timeout counts as a failure
  task automatic wait_slot(input string tag, input logic [1:0] want);
    int n;
    n = 0;
    while (dig_sel !== want && n < 4 * SCAN_DIV) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_slot"}, {6'd0, dig_sel}, {6'd0, want});
  endtask

  task automatic do_tick(input logic [1:0] st, input logic [3:0] t);
    tick_en     = 1'b1;
    light_state = st;
    time_left   = t;
    @(negedge clk);
    tick_en     = 1'b0;
    light_state = ~st;
    time_left   = ~t;
  endtask

  logic [1:0] prev_sel;
  logic [1:0] exp_sel;

  initial begin
    rst_n       = 1'b0;
    tick_en     = 1'b0;
    light_state = 2'b00;
    time_left   = 4'd0;
    cycles(2);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_dig", {6'd0, dig_sel}, 8'h03);
    chk("rst_blink", {7'd0, blink}, 8'h00);

    // No tick: dashes in both slots, ones first
    rst_n = 1'b1;
    cycles(3);
    chk("pre_wrap_dig", {6'd0, dig_sel}, 8'h03);
    cycles(1);
    chk("wrap1_dig", {6'd0, dig_sel}, 8'h02);
    chk("wrap1_seg", seg, 8'hBF);
    cycles(4);
    chk("wrap2_dig", {6'd0, dig_sel}, 8'h01);
    chk("wrap2_seg", seg, 8'hBF);

    // S1, 15 -> " 15" with inputs scrambled afterwards
    do_tick(2'b00, 4'd15);
    chk("s1_blink", {7'd0, blink}, 8'h00);
    wait_slot("s1_ones", 2'b10);
    chk("s1_ones_seg", seg, 8'h92);
    wait_slot("s1_tens", 2'b01);
    chk("s1_tens_seg", seg, 8'hF9);

    // S3, 7 -> tens blanked
    do_tick(2'b10, 4'd7);
    wait_slot("s3_ones", 2'b10);
    chk("s3_ones_seg", seg, 8'hF8);
    wait_slot("s3_tens", 2'b01);
    chk("s3_tens_seg", seg, 8'hFF);

    // S2 countdown with blink toggling
    do_tick(2'b01, 4'd3);
    chk("s2a_blink", {7'd0, blink}, 8'h01);
    chk("s2a_seg", seg, 8'hFF);
    chk("s2a_scan", {7'd0, (dig_sel == 2'b10 || dig_sel == 2'b01)}, 8'h01);
    do_tick(2'b01, 4'd2);
    chk("s2b_blink", {7'd0, blink}, 8'h00);
    wait_slot("s2b_ones", 2'b10);
    chk("s2b_ones_seg", seg, 8'hA4);
    do_tick(2'b01, 4'd1);
    chk("s2c_blink", {7'd0, blink}, 8'h01);
    wait_slot("s2c_ones", 2'b10);
    chk("s2c_ones_seg", seg, 8'hFF);

    // Back-to-back S4 ticks toggle twice
    tick_en     = 1'b1;
    light_state = 2'b11;
    time_left   = 4'd9;
    @(negedge clk);
    chk("b2b_first_blink", {7'd0, blink}, 8'h00);
    do_tick(2'b11, 4'd9);
    chk("b2b_second_blink", {7'd0, blink}, 8'h01);
    chk("b2b_seg", seg, 8'hFF);

    // S1, 0 -> " 0", blink cleared
    do_tick(2'b00, 4'd0);
    chk("zero_blink", {7'd0, blink}, 8'h00);
    wait_slot("zero_ones", 2'b10);
    chk("zero_ones_seg", seg, 8'hC0);
    wait_slot("zero_tens", 2'b01);
    chk("zero_tens_seg", seg, 8'hFF);

    // Tick coincident with scan wrap: sit on the cycle just after a wrap, then count up
    prev_sel = dig_sel;
    wait_slot("align", ~prev_sel);
    cycles(SCAN_DIV - 1);
    prev_sel = dig_sel;
    exp_sel  = (prev_sel == 2'b10) ? 2'b01 : 2'b10;
    do_tick(2'b00, 4'd12);
    chk("wrap_tick_dig", {6'd0, dig_sel}, {6'd0, exp_sel});
    chk("wrap_tick_seg", seg, (exp_sel == 2'b10) ? 8'hA4 : 8'hF9);

    // Reset mid-scan overrides a simultaneous yellow tick
    cycles(1);
    rst_n       = 1'b0;
    tick_en     = 1'b1;
    light_state = 2'b01;
    time_left   = 4'd5;
    @(negedge clk);
    chk("mid_rst_seg", seg, 8'hFF);
    chk("mid_rst_dig", {6'd0, dig_sel}, 8'h03);
    chk("mid_rst_blink", {7'd0, blink}, 8'h00);
    rst_n   = 1'b1;
    tick_en = 1'b0;
    cycles(3);
    chk("restart_pre_dig", {6'd0, dig_sel}, 8'h03);
    cycles(1);
    chk("restart_dig", {6'd0, dig_sel}, 8'h02);
    chk("restart_seg", seg, 8'hBF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_display.md
COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 Parameter SCAN_DIV, default 6000, clock cycles per digit slot (12 MHz / 6000 = 2 kHz digit rate); legal range 2..2^20.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 tick_en  input  1  one-cycle 1 Hz enable from the traffic controller; qualifies light_state/time_left.
REQ-005 light_state  input  2  controller phase: S1=00 main-green, S2=01 main-yellow, S3=10 side-green, S4=11 side-yellow.
REQ-006 time_left  input  4  seconds remaining in phase, 0..15.
REQ-007 seg  output  8  registered, active-low {dp,g,f,e,d,c,b,a}; dp always 1.
REQ-008 dig_sel  output  2  registered, active-low digit enable; bit0 ones, bit1 tens.
REQ-009 blink  output  1  registered blink phase, for an external buzzer/LED.

Function
REQ-010 Capture: on cycle with tick_en=1, state_q<=light_state, time_q<=time_left, valid<=1; new values affect seg from the next cycle.
REQ-011 Between ticks, state_q/time_q SHALL hold; inputs ignored when tick_en=0.
REQ-012 BCD split: tens=1 when time_q>=10, ones=time_q-10*tens; 4-bit arithmetic, no overflow path.
REQ-013 Leading-zero blanking: tens slot outputs BLANK (8'hFF) when tens=0; time_q=0 shows " 0".
REQ-014 Segment codes 0..9: C0,F9,A4,B0,99,92,82,F8,80,90 (hex); DASH=8'hBF; BLANK=8'hFF.
REQ-015 Scan counter runs 0..SCAN_DIV-1 and wraps; on wrap dig_sel alternates 2'b10 (ones) / 2'b01 (tens); first wrap after reset selects ones.
REQ-016 seg SHALL always carry the code for the digit currently enabled by dig_sel in the same cycle; exactly one dig_sel bit low after first wrap.
REQ-017 Not valid (no tick since reset): both slots show DASH.
REQ-018 Blink: in S2/S4, blink toggles on every tick_en; in S1/S3 blink forced 0 on the capturing tick.
REQ-019 blink=1 SHALL force seg=BLANK; dig_sel scanning continues unaffected.
REQ-020 Back-to-back tick_en cycles: each cycle captures and toggles blink; no error state.
REQ-021 tick_en coincident with scan wrap: digit advances and capture occurs in the same cycle; no slot skipped.

Reset
REQ-022 rst_n=0 at a rising edge: seg=8'hFF, dig_sel=2'b11, blink=0, scan counter=0, valid=0, state_q=S1, time_q=0.
REQ-023 Reset mid-operation SHALL override tick_en and scan wrap in the same edge; scanning restarts from count 0.

Structure
REQ-024 Package traffic_pkg SHALL hold the S1..S4 encodings, digit segment codes, DASH and BLANK constants.
REQ-025 One combinational sub-module seg7_decode (4-bit digit -> 8-bit active-low code, non-decimal -> BLANK).
REQ-026 Scan counter width SHALL be $clog2(SCAN_DIV).

Verification
REQ-027 Reset, no tick, SCAN_DIV=4: after 4 cycles dig_sel=10 seg=BF, after 8 dig_sel=01 seg=BF.
REQ-028 tick_en with S1, time_left=15: ones slot seg=92, tens slot seg=F9, blink=0.
REQ-029 tick_en with S3, time_left=7: ones slot seg=F8, tens slot seg=FF.
REQ-030 Three ticks in S2, time_left 3,2,1: blink 1,0,1; seg=FF during blink=1, ones slot B0/A4/F9 otherwise.
REQ-031 tick_en on the scan-wrap cycle, then rst_n=0 mid-scan: capture visible next cycle; after reset all outputs match REQ-022.
